// File: rtl/axis_packetizer_pkg.sv
// Shared router definitions: reserved header TID, header field layout and packetizer FSM states.
// The router-side decoder imports the same layout so encoder and decoder never drift apart.
package axis_packetizer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } pkt_state_e;

  // TID value reserved for routing headers; legal payload masters never emit it.
  localparam int ROUTING_HEADER = 'hF;
  localparam int HDR_LEN_W      = 8;

  function automatic int hdr_dst_y_lsb(input int xw, input int yw);
    return 0;
  endfunction

  function automatic int hdr_dst_x_lsb(input int xw, input int yw);
    return xw;
  endfunction

  function automatic int hdr_src_y_lsb(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int hdr_src_x_lsb(input int xw, input int yw);
    return 2 * xw + yw;
  endfunction

  function automatic int hdr_len_lsb(input int xw, input int yw);
    return 2 * (xw + yw);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake with data and ID.
interface axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [ID_WIDTH-1:0]   tid;

  modport m (output tvalid, output tdata, output tid, input tready);
  modport s (input tvalid, input tdata, input tid, output tready);
endinterface

// File: rtl/axis_header_pack.sv
// Combinational routing-header builder: packs destination, source and payload length into one flit.
module axis_header_pack
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int XW         = 2,
  parameter int YW         = 2
) (
  input  logic [XW-1:0]         dst_x,
  input  logic [YW-1:0]         dst_y,
  input  logic [XW-1:0]         src_x,
  input  logic [YW-1:0]         src_y,
  input  logic [7:0]            len,
  output logic [DATA_WIDTH-1:0] tdata
);

  localparam int DY_LSB  = hdr_dst_y_lsb(XW, YW);
  localparam int DX_LSB  = hdr_dst_x_lsb(XW, YW);
  localparam int SY_LSB  = hdr_src_y_lsb(XW, YW);
  localparam int SX_LSB  = hdr_src_x_lsb(XW, YW);
  localparam int LEN_LSB = hdr_len_lsb(XW, YW);

  // Field widths follow the shared layout: y slots are XW wide, x slots YW wide.
  always_comb begin
    tdata                      = '0;
    tdata[DY_LSB +: XW]        = XW'(dst_y);
    tdata[DX_LSB +: YW]        = YW'(dst_x);
    tdata[SY_LSB +: XW]        = XW'(src_y);
    tdata[SX_LSB +: YW]        = YW'(src_x);
    tdata[LEN_LSB +: HDR_LEN_W] = len;
  end

endmodule

// File: rtl/axis_packetizer.sv
// Wraps a payload stream into mesh packets: one routing-header flit, then req_len pass-through flits.
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int SRC_X         = 0,
  parameter int SRC_Y         = 0,
  localparam int XW           = $clog2(MAX_ROUTERS_X),
  localparam int YW           = $clog2(MAX_ROUTERS_Y)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic [7:0]    req_len,
  axis_if.s             in,
  axis_if.m             out,
  output logic          busy,
  output logic          err_len,
  output logic [15:0]   pkt_count
);

  if (DATA_WIDTH < hdr_len_lsb(XW, YW) + HDR_LEN_W) begin : g_width_check
    $error("axis_packetizer: DATA_WIDTH too narrow for routing header");
  end

  pkt_state_e            state, state_next;
  logic [XW-1:0]         dst_x;
  logic [YW-1:0]         dst_y;
  logic [7:0]            len;
  logic [7:0]            remaining;
  logic [DATA_WIDTH-1:0] header;
  logic                  req_fire, hdr_fire, pay_fire, last_fire;

  axis_header_pack #(
    .DATA_WIDTH(DATA_WIDTH),
    .XW        (XW),
    .YW        (YW)
  ) u_header_pack (
    .dst_x(dst_x),
    .dst_y(dst_y),
    .src_x(XW'(SRC_X)),
    .src_y(YW'(SRC_Y)),
    .len  (len),
    .tdata(header)
  );

  assign req_fire  = (state == IDLE) && req_valid;
  assign hdr_fire  = (state == HEADER) && out.tready;
  assign pay_fire  = (state == PAYLOAD) && in.tvalid && out.tready;
  assign last_fire = pay_fire && (remaining == 8'd1);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every output is defaulted before the case so no path leaves one unassigned and infers a latch.
    state_next = state;
    req_ready  = 1'b0;
    out.tvalid = 1'b0;
    out.tdata  = '0;
    out.tid    = '0;
    in.tready  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && (req_len != 8'd0)) state_next = HEADER;
      end
      HEADER: begin
        out.tvalid = 1'b1;
        out.tdata  = header;
        out.tid    = ID_WIDTH'(ROUTING_HEADER);
        if (out.tready) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        out.tvalid = in.tvalid;
        out.tdata  = in.tdata;
        out.tid    = in.tid;
        in.tready  = out.tready;
        if (last_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      dst_x     <= '0;
      dst_y     <= '0;
      len       <= '0;
      remaining <= '0;
      err_len   <= 1'b0;
      pkt_count <= '0;
    end else begin
      state   <= state_next;
      err_len <= req_fire && (req_len == 8'd0);
      if (req_fire) begin
        dst_x <= req_x;
        dst_y <= req_y;
        len   <= req_len;
      end
      if (hdr_fire) remaining <= len;
      else if (pay_fire) remaining <= remaining - 8'd1;
      if (last_fire) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: header layout, stalls, zero length, back-to-back, reset abort, long packet.
module tb_axis_packetizer;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam logic [IW-1:0] HDR_TID = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_x, req_y;
  logic [7:0]  req_len;
  logic        busy, err_len;
  logic [15:0] pkt_count;
  logic [15:0] exp_count = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) pin ();
  axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) pout ();

  axis_packetizer #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .SRC_X(0), .SRC_Y(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_len(req_len), .in(pin), .out(pout),
    .busy(busy), .err_len(err_len), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_x       = '0;
    req_y       = '0;
    req_len     = '0;
    pin.tvalid  = 1'b0;
    pin.tdata   = '0;
    pin.tid     = '0;
    pout.tready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (pout.tvalid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", pout.tvalid); else n_pass++;
    n_checks++; if (pin.tready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", pin.tready); else n_pass++;
    n_checks++; if (err_len !== 1'b0) $display("FAIL rst_err_len: got %b want 0", err_len); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  // Expected header for src (0,0): [1:0]=y, [3:2]=x, [15:8]=len.
  task automatic test_basic();
    @(negedge clk);
    req_valid = 1'b1; req_x = 2'd2; req_y = 2'd1; req_len = 8'd3;
    pin.tvalid = 1'b1; pin.tdata = 32'hDEAD_0000; pin.tid = 4'h1; pout.tready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL basic_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (pout.tvalid !== 1'b0) $display("FAIL basic_idle_valid: got %b want 0", pout.tvalid); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (pout.tvalid !== 1'b1) $display("FAIL basic_hdr_valid: got %b want 1", pout.tvalid); else n_pass++;
    n_checks++; if (pout.tid !== HDR_TID) $display("FAIL basic_hdr_tid: got %h want %h", pout.tid, HDR_TID); else n_pass++;
    n_checks++; if (pout.tdata !== 32'h0000_0309) $display("FAIL basic_hdr_tdata: got %h want 00000309", pout.tdata); else n_pass++;
    n_checks++; if (pin.tready !== 1'b0) $display("FAIL basic_hdr_in_ready: got %b want 0", pin.tready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pin.tdata = 32'hA5A5_0000 + 32'(i);
      pin.tid   = IW'(i + 2);
      #1;
      n_checks++; if (pout.tdata !== 32'hA5A5_0000 + 32'(i)) $display("FAIL basic_pay%0d_tdata: got %h want %h", i, pout.tdata, 32'hA5A5_0000 + 32'(i)); else n_pass++;
      n_checks++; if (pout.tid !== IW'(i + 2)) $display("FAIL basic_pay%0d_tid: got %h want %h", i, pout.tid, IW'(i + 2)); else n_pass++;
      n_checks++; if (pin.tready !== 1'b1) $display("FAIL basic_pay%0d_in_ready: got %b want 1", i, pin.tready); else n_pass++;
    end
    exp_count++;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_end_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (pout.tvalid !== 1'b0) $display("FAIL basic_end_valid: got %b want 0", pout.tvalid); else n_pass++;
    n_checks++; if (pkt_count !== exp_count) $display("FAIL basic_pkt_count: got %0d want %0d", pkt_count, exp_count); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_header_stall();
    @(negedge clk);
    req_valid = 1'b1; req_x = 2'd2; req_y = 2'd1; req_len = 8'd3;
    pin.tvalid = 1'b1; pin.tdata = 32'h1234_5678; pout.tready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      n_checks++; if (pout.tvalid !== 1'b1 || pout.tdata !== 32'h0000_0309 || pout.tid !== HDR_TID)
        $display("FAIL stall_hdr_c%0d: got v=%b d=%h id=%h want v=1 d=00000309 id=%h", c, pout.tvalid, pout.tdata, pout.tid, HDR_TID);
      else n_pass++;
      n_checks++; if (pin.tready !== 1'b0) $display("FAIL stall_in_ready_c%0d: got %b want 0", c, pin.tready); else n_pass++;
    end
    pout.tready = 1'b1;
    repeat (4) @(negedge clk);
    exp_count++;
    #1;
    n_checks++; if (busy !== 1'b0 || pkt_count !== exp_count) $display("FAIL stall_end: got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, pkt_count, exp_count); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    req_valid = 1'b1; req_x = 2'd3; req_y = 2'd3; req_len = 8'd0;
    pin.tvalid = 1'b1; pout.tready = 1'b1;
    #1;
    n_checks++; if (err_len !== 1'b0) $display("FAIL zero_err_before: got %b want 0", err_len); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (err_len !== 1'b1) $display("FAIL zero_err_pulse: got %b want 1", err_len); else n_pass++;
    n_checks++; if (pout.tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL zero_no_packet: got v=%b busy=%b want 0 0", pout.tvalid, busy); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (err_len !== 1'b0) $display("FAIL zero_err_after: got %b want 0", err_len); else n_pass++;
    n_checks++; if (pkt_count !== exp_count) $display("FAIL zero_pkt_count: got %0d want %0d", pkt_count, exp_count); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1; req_x = 2'd1; req_y = 2'd3; req_len = 8'd1;
    pin.tvalid = 1'b1; pin.tdata = 32'hB000_0001; pin.tid = 4'h3; pout.tready = 1'b1;
    @(negedge clk);
    req_x = 2'd3; req_y = 2'd2; req_len = 8'd2;
    #1;
    n_checks++; if (pout.tid !== HDR_TID || pout.tdata !== 32'h0000_0107) $display("FAIL b2b_hdr1: got id=%h d=%h want id=%h d=00000107", pout.tid, pout.tdata, HDR_TID); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (pout.tid !== 4'h3 || pout.tdata !== 32'hB000_0001) $display("FAIL b2b_p1: got id=%h d=%h want id=3 d=b0000001", pout.tid, pout.tdata); else n_pass++;
    exp_count++;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || pout.tvalid !== 1'b0) $display("FAIL b2b_gap: got rdy=%b v=%b want rdy=1 v=0", req_ready, pout.tvalid); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (pout.tid !== HDR_TID || pout.tdata !== 32'h0000_020E) $display("FAIL b2b_hdr2: got id=%h d=%h want id=%h d=0000020e", pout.tid, pout.tdata, HDR_TID); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pin.tdata = 32'hB100_0000 + 32'(i); pin.tid = IW'(5 + i);
      #1;
      n_checks++; if (pout.tid !== IW'(5 + i) || pout.tdata !== 32'hB100_0000 + 32'(i)) $display("FAIL b2b_p2_%0d: got id=%h d=%h want id=%h", i, pout.tid, pout.tdata, IW'(5 + i)); else n_pass++;
    end
    exp_count++;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0 || pkt_count !== exp_count) $display("FAIL b2b_end: got busy=%b cnt=%0d want busy=0 cnt=%0d", busy, pkt_count, exp_count); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    req_valid = 1'b1; req_x = 2'd1; req_y = 2'd1; req_len = 8'd5;
    pin.tvalid = 1'b1; pin.tdata = 32'hC0DE_0000; pout.tready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (pout.tvalid !== 1'b1 || busy !== 1'b1) $display("FAIL rmid_pre: got v=%b busy=%b want 1 1", pout.tvalid, busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pout.tvalid !== 1'b0 || pin.tready !== 1'b0) $display("FAIL rmid_drop: got v=%b rdy=%b want 0 0", pout.tvalid, pin.tready); else n_pass++;
    exp_count = '0;
    n_checks++; if (pkt_count !== exp_count || busy !== 1'b0) $display("FAIL rmid_state: got cnt=%0d busy=%b want 0 0", pkt_count, busy); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if (pout.tvalid !== 1'b0) $display("FAIL rmid_quiet_c%0d: got %b want 0", c, pout.tvalid); else n_pass++;
    end
    @(negedge clk);
    req_valid = 1'b1; req_x = 2'd2; req_y = 2'd1; req_len = 8'd1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (pout.tid !== HDR_TID || pout.tdata !== 32'h0000_0109) $display("FAIL rmid_hdr: got id=%h d=%h want id=%h d=00000109", pout.tid, pout.tdata, HDR_TID); else n_pass++;
    repeat (2) @(negedge clk);
    exp_count++;
    #1;
    n_checks++; if (pkt_count !== exp_count || busy !== 1'b0) $display("FAIL rmid_count: got cnt=%0d busy=%b want cnt=%0d busy=0", pkt_count, busy, exp_count); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_len255();
    int  flits = 0;
    int  bad = 0;
    bit  hdr_done = 1'b0;
    bit  finished = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_x = 2'd3; req_y = 2'd3; req_len = 8'd255;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      req_valid   = 1'b0;
      pin.tvalid  = ($urandom_range(0, 3) != 0);
      pout.tready = ($urandom_range(0, 3) != 0);
      pin.tdata   = 32'hF000_0000 | 32'(flits);
      pin.tid     = IW'(flits % 15);
      #1;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      if (pout.tvalid && pout.tready) begin
        if (!hdr_done) begin
          if (pout.tid !== HDR_TID || pout.tdata !== 32'h0000_FF0F) bad++;
          hdr_done = 1'b1;
        end else begin
          if (pout.tdata !== (32'hF000_0000 | 32'(flits)) || pin.tready !== 1'b1) bad++;
          flits++;
        end
      end
    end
    exp_count++;
    n_checks++; if (!finished) $display("FAIL long_timeout: got busy after 4000 cycles want idle"); else n_pass++;
    n_checks++; if (flits != 255) $display("FAIL long_flits: got %0d want 255", flits); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL long_data: got %0d bad transfers want 0", bad); else n_pass++;
    n_checks++; if (pkt_count !== exp_count) $display("FAIL long_pkt_count: got %0d want %0d", pkt_count, exp_count); else n_pass++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header_stall();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_packet();
    test_len255();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
